demux12_octal: RTL

// - Registered 1:2 demultiplexer for a WIDTH-bit byte stream; the distribution counterpart of the octal 2:1 select path.
// - Routes each accepted input byte to output channel A or B, chosen by explicit select or by auto-alternation.
// - Each channel has a one-entry holding register with valid/ready handshake and a delivered-byte counter.
// - Sits between a single byte producer and two independent consumers.

---
 rtl/demux12_octal.sv | 103 ++++++++++
 1 files changed

// File: rtl/demux12_octal.sv
// ============================================================================
// Module      : demux12_octal
// Description : Registered 1:2 byte-stream demultiplexer with per-channel
//               one-entry holding registers and delivered-byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux12_octal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             se,
    input  logic             auto,
    input  logic             en,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             full_a;
    logic             full_b;
    logic             toggle;

    logic             target;
    logic             full_t;
    logic             ready_t;
    logic             accept;
    logic             load_a;
    logic             load_b;
    logic             drain_a;
    logic             drain_b;

    // Target depends only on mode/select state, never on in_valid.
    assign target   = auto ? toggle : se;
    assign full_t   = target ? full_b  : full_a;
    assign ready_t  = target ? b_ready : a_ready;
    assign in_ready = en & (~full_t | ready_t);
    assign accept   = in_valid & in_ready;
    assign load_a   = accept & ~target;
    assign load_b   = accept & target;
    assign drain_a  = full_a & a_ready & en;
    assign drain_b  = full_b & b_ready & en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            full_a <= 1'b0;
            full_b <= 1'b0;
            toggle <= 1'b0;
            a_cnt  <= '0;
            b_cnt  <= '0;
        end else begin
            if (load_a) begin
                reg_a <= in_data;
            end
            if (load_b) begin
                reg_b <= in_data;
            end
            // A load in the same edge as a drain keeps the channel full.
            if (load_a) begin
                full_a <= 1'b1;
            end else if (drain_a) begin
                full_a <= 1'b0;
            end
            if (load_b) begin
                full_b <= 1'b1;
            end else if (drain_b) begin
                full_b <= 1'b0;
            end
            if (accept && auto) begin
                toggle <= ~toggle;
            end
            if (drain_a) begin
                a_cnt <= a_cnt + 1'b1;
            end
            if (drain_b) begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end

    assign a_valid = full_a & en;
    assign b_valid = full_b & en;
    assign a_data  = en ? reg_a : {WIDTH{1'bz}};
    assign b_data  = en ? reg_b : {WIDTH{1'bz}};

endmodule

`default_nettype wire
